// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and defaults for the hazard/stall sequencer of the 5-stage core.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 8;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit bundle: ID/EX instruction fields in, pipeline-register controls out.
interface hazard_stall_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             Rs_Id;
  logic [4:0]             Rt_Id;
  logic [4:0]             Rt_Ex;
  logic                   MemRead_Ex;
  logic                   Br_Taken_Id;
  logic                   MulDiv_Id;
  logic                   HiLo_Use_Id;
  logic                   Stall_Clr;
  logic                   PC_Write;
  logic                   IF_ID_Write;
  logic                   IF_ID_Flush;
  logic                   ID_EX_Bubble;
  logic                   MD_Start;
  logic                   MD_Busy;
  logic [STALL_CNT_W-1:0] Stall_Cnt;

  modport master (
    output Rs_Id, Rt_Id, Rt_Ex, MemRead_Ex, Br_Taken_Id, MulDiv_Id, HiLo_Use_Id, Stall_Clr,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Start, MD_Busy, Stall_Cnt
  );

  modport slave (
    input  Rs_Id, Rt_Id, Rt_Ex, MemRead_Ex, Br_Taken_Id, MulDiv_Id, HiLo_Use_Id, Stall_Clr,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Start, MD_Busy, Stall_Cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     count <= '0;
    else if (clr)   count <= '0;
    else if (inc)   count <= sat_inc(count);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / mul-div hazard detection, pipeline stall and flush control,
// mul/div occupancy FSM and stall-cycle performance counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = MD_LATENCY_DEF,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic clock,
  input  logic reset,
  hazard_stall_ctrl_if.slave hz
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             busy_q, busy_d;
  logic             load_use, md_hazard, stall, md_start;

  always_comb begin
    load_use  = hz.MemRead_Ex && (hz.Rt_Ex != REG_ZERO) &&
                ((hz.Rt_Ex == hz.Rs_Id) || (hz.Rt_Ex == hz.Rt_Id));
    md_hazard = (state_q == MD_RUN) && (hz.MulDiv_Id || hz.HiLo_Use_Id);
    stall     = load_use || md_hazard;
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    busy_d    = busy_q;
    md_start  = 1'b0;
    case (state_q)
      IDLE: begin
        // md_hazard is never set in IDLE, so load_use is the only blocker.
        if (hz.MulDiv_Id && !load_use) begin
          md_start  = 1'b1;
          state_d   = MD_RUN;
          lat_cnt_d = CNT_W'(MD_LATENCY - 1);
          busy_d    = 1'b1;
        end
      end
      MD_RUN: begin
        if (lat_cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are held at their run-freely values while reset is asserted.
  assign hz.PC_Write     = !reset || !stall;
  assign hz.IF_ID_Write  = !reset || !stall;
  assign hz.IF_ID_Flush  = reset && !stall && hz.Br_Taken_Id;
  assign hz.ID_EX_Bubble = reset && stall;
  assign hz.MD_Start     = reset && md_start;
  assign hz.MD_Busy      = busy_q;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (hz.Stall_Clr),
    .inc   (stall),
    .count (hz.Stall_Cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic.
module tb_hazard_stall_ctrl;
  localparam int L = 8;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  // Reference model: busy cycles remaining and stall count, as plain integers.
  int   m_left, m_cnt, n_left, n_cnt;
  logic e_pc, e_ifid, e_flush, e_bub, e_start, e_busy;
  logic [15:0] e_cnt;

  hazard_stall_ctrl_if #(.STALL_CNT_W(16)) hz ();

  hazard_stall_ctrl #(
    .MD_LATENCY  (L),
    .CNT_W       (4),
    .STALL_CNT_W (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic clear_inputs();
    hz.Rs_Id = 5'd0; hz.Rt_Id = 5'd0; hz.Rt_Ex = 5'd0;
    hz.MemRead_Ex = 1'b0; hz.Br_Taken_Id = 1'b0; hz.MulDiv_Id = 1'b0;
    hz.HiLo_Use_Id = 1'b0; hz.Stall_Clr = 1'b0;
  endtask

  task automatic model_eval();
    bit lu, running, st, start;
    lu      = hz.MemRead_Ex && (hz.Rt_Ex != 0) && ((hz.Rt_Ex == hz.Rs_Id) || (hz.Rt_Ex == hz.Rt_Id));
    running = (m_left > 0);
    st      = lu || (running && (hz.MulDiv_Id || hz.HiLo_Use_Id));
    start   = !running && hz.MulDiv_Id && !lu;
    if (!reset) begin
      {e_pc, e_ifid, e_flush, e_bub, e_start, e_busy} = 6'b110000;
      e_cnt  = 16'h0;
      n_left = 0;
      n_cnt  = 0;
    end else begin
      e_pc    = !st;
      e_ifid  = !st;
      e_flush = !st && hz.Br_Taken_Id;
      e_bub   = st;
      e_start = start;
      e_busy  = running;
      e_cnt   = 16'(m_cnt);
      n_left  = start ? L : (running ? m_left - 1 : 0);
      if (hz.Stall_Clr)   n_cnt = 0;
      else if (st)        n_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      else                n_cnt = m_cnt;
    end
  endtask

  task automatic advance();
    model_eval();
    @(posedge clock);
    m_left = n_left;
    m_cnt  = n_cnt;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_left = 0; m_cnt = 0;
    clear_inputs();
    hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd8; hz.Rs_Id = 5'd8; hz.MulDiv_Id = 1; hz.HiLo_Use_Id = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.MD_Start, hz.MD_Busy, hz.Stall_Cnt}
          !== {6'b110000, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b_%h required 110000_0000",
                 {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.MD_Start, hz.MD_Busy},
                 hz.Stall_Cnt);
      end
      advance();
    end
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_load_use();
    int c0;
    clear_inputs();
    hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd8; hz.Rs_Id = 5'd8; hz.Rt_Id = 5'd3;
    c0 = m_cnt;
    @(negedge clock);
    n_cmp++;
    if ({hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Bubble, hz.Stall_Cnt} !== {3'b001, 16'h0}) begin
      n_fail++;
      $display("FAIL load_use_stall: got pc/ifid/bub=%b cnt=%0d required 001 cnt=0",
               {hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Bubble}, hz.Stall_Cnt);
    end
    advance();
    clear_inputs();
    @(negedge clock);
    n_cmp++;
    if (hz.Stall_Cnt !== 16'(c0 + 1) || hz.PC_Write !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_count: got cnt=%0d pc=%b required cnt=%0d pc=1", hz.Stall_Cnt, hz.PC_Write, c0 + 1);
    end
    advance();
    hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd0; hz.Rs_Id = 5'd0; hz.Rt_Id = 5'd0;
    @(negedge clock);
    n_cmp++;
    if ({hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Bubble} !== 3'b110) begin
      n_fail++;
      $display("FAIL load_use_r0: got pc/ifid/bub=%b required 110", {hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Bubble});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    hz.Br_Taken_Id = 1;
    @(negedge clock);
    n_cmp++;
    if ({hz.IF_ID_Flush, hz.PC_Write, hz.ID_EX_Bubble} !== 3'b110) begin
      n_fail++;
      $display("FAIL branch_flush: got flush/pc/bub=%b required 110", {hz.IF_ID_Flush, hz.PC_Write, hz.ID_EX_Bubble});
    end
    advance();
    hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd5; hz.Rt_Id = 5'd5; hz.Rs_Id = 5'd1;
    @(negedge clock);
    n_cmp++;
    if ({hz.IF_ID_Flush, hz.PC_Write, hz.ID_EX_Bubble} !== 3'b001) begin
      n_fail++;
      $display("FAIL branch_held: got flush/pc/bub=%b required 001", {hz.IF_ID_Flush, hz.PC_Write, hz.ID_EX_Bubble});
    end
    advance();
    hz.MemRead_Ex = 0;
    @(negedge clock);
    n_cmp++;
    if ({hz.IF_ID_Flush, hz.PC_Write} !== 2'b11) begin
      n_fail++;
      $display("FAIL branch_release: got flush/pc=%b required 11", {hz.IF_ID_Flush, hz.PC_Write});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_muldiv_issue();
    int busy_cycles;
    clear_inputs();
    hz.MulDiv_Id = 1;
    @(negedge clock);
    n_cmp++;
    if (hz.MD_Start !== 1'b1 || hz.MD_Busy !== 1'b0 || hz.PC_Write !== 1'b1) begin
      n_fail++;
      $display("FAIL md_start: got start=%b busy=%b pc=%b required 1 0 1", hz.MD_Start, hz.MD_Busy, hz.PC_Write);
    end
    advance();
    hz.MulDiv_Id = 0;
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (hz.MD_Busy === 1'b1) busy_cycles++;
      n_cmp++;
      if (hz.MD_Start !== 1'b0) begin
        n_fail++;
        $display("FAIL md_start_pulse: cycle %0d got start=%b required 0", i, hz.MD_Start);
      end
      advance();
    end
    n_cmp++;
    if (busy_cycles != L) begin
      n_fail++;
      $display("FAIL md_busy_len: got %0d busy cycles required %0d", busy_cycles, L);
    end
  endtask

  task automatic test_hilo();
    int stalls;
    bit released;
    clear_inputs();
    hz.Stall_Clr = 1;
    advance();
    hz.Stall_Clr = 0;
    hz.MulDiv_Id = 1;
    advance();
    hz.MulDiv_Id = 0;
    advance();
    advance();
    hz.HiLo_Use_Id = 1;
    stalls = 0;
    released = 0;
    for (int i = 0; i < 20 && !released; i++) begin
      @(negedge clock);
      if (hz.PC_Write === 1'b1) begin
        released = 1;
        n_cmp++;
        if (hz.MD_Busy !== 1'b0 || hz.Stall_Cnt !== 16'd6) begin
          n_fail++;
          $display("FAIL hilo_release: got busy=%b cnt=%0d required busy=0 cnt=6", hz.MD_Busy, hz.Stall_Cnt);
        end
      end else begin
        stalls++;
      end
      advance();
    end
    n_cmp++;
    if (stalls != 6 || !released) begin
      n_fail++;
      $display("FAIL hilo_stalls: got %0d stall cycles released=%0d required 6 released=1", stalls, released);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int waits;
    bit started;
    clear_inputs();
    hz.MulDiv_Id = 1;
    advance();
    waits = 0;
    started = 0;
    for (int i = 0; i < 20 && !started; i++) begin
      @(negedge clock);
      if (hz.MD_Start === 1'b1) begin
        started = 1;
        n_cmp++;
        if (hz.MD_Busy !== 1'b0 || hz.PC_Write !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_start_state: got busy=%b pc=%b required 0 1", hz.MD_Busy, hz.PC_Write);
        end
      end else begin
        waits++;
      end
      advance();
    end
    n_cmp++;
    if (waits != L || !started) begin
      n_fail++;
      $display("FAIL b2b_wait: got %0d wait cycles started=%0d required %0d started=1", waits, started, L);
    end
    hz.MulDiv_Id = 0;
    @(negedge clock);
    n_cmp++;
    if (hz.MD_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: got busy=%b required 1", hz.MD_Busy);
    end
    for (int i = 0; i < L; i++) advance();
    hz.MulDiv_Id = 1; hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd9; hz.Rs_Id = 5'd9;
    @(negedge clock);
    n_cmp++;
    if (hz.MD_Start !== 1'b0 || hz.ID_EX_Bubble !== 1'b1 || hz.MD_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL md_loaduse: got start=%b bub=%b busy=%b required 0 1 0", hz.MD_Start, hz.ID_EX_Bubble, hz.MD_Busy);
    end
    advance();
    clear_inputs();
    @(negedge clock);
    n_cmp++;
    if (hz.MD_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL md_loaduse_nostart: got busy=%b required 0", hz.MD_Busy);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    hz.MulDiv_Id = 1;
    advance();
    hz.MulDiv_Id = 0; hz.HiLo_Use_Id = 1;
    for (int i = 0; i < 3; i++) advance();
    hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd4; hz.Rs_Id = 5'd4;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (hz.MD_Busy !== 1'b0 || hz.Stall_Cnt !== 16'h0 || hz.PC_Write !== 1'b1 || hz.ID_EX_Bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b cnt=%0d pc=%b bub=%b required 0 0 1 0",
               hz.MD_Busy, hz.Stall_Cnt, hz.PC_Write, hz.ID_EX_Bubble);
    end
    advance();
    reset = 1'b1;
    hz.MemRead_Ex = 0;
    @(negedge clock);
    n_cmp++;
    if (hz.PC_Write !== 1'b1 || hz.MD_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got pc=%b busy=%b required 1 0", hz.PC_Write, hz.MD_Busy);
    end
    advance();
    hz.HiLo_Use_Id = 0; hz.MulDiv_Id = 1;
    @(negedge clock);
    n_cmp++;
    if (hz.MD_Start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart: got start=%b required 1", hz.MD_Start);
    end
    advance();
    clear_inputs();
    for (int i = 0; i < L; i++) advance();
  endtask

  task automatic test_saturation();
    clear_inputs();
    hz.MemRead_Ex = 1; hz.Rt_Ex = 5'd2; hz.Rt_Id = 5'd2;
    for (int i = 0; i < 65540; i++) advance();
    @(negedge clock);
    model_eval();
    n_cmp++;
    if (hz.Stall_Cnt !== 16'hFFFF || hz.Stall_Cnt !== e_cnt) begin
      n_fail++;
      $display("FAIL stall_saturate: got %h required ffff (model %h)", hz.Stall_Cnt, e_cnt);
    end
    hz.Stall_Clr = 1;
    advance();
    hz.Stall_Clr = 0;
    clear_inputs();
    @(negedge clock);
    n_cmp++;
    if (hz.Stall_Cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL stall_clear: got %h required 0000", hz.Stall_Cnt);
    end
    advance();
  endtask

  task automatic test_random();
    logic [21:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      hz.Rs_Id       = 5'($urandom_range(0, 3));
      hz.Rt_Id       = 5'($urandom_range(0, 3));
      hz.Rt_Ex       = 5'($urandom_range(0, 3));
      hz.MemRead_Ex  = ($urandom_range(0, 99) < 30);
      hz.MulDiv_Id   = ($urandom_range(0, 99) < 15);
      hz.HiLo_Use_Id = ($urandom_range(0, 99) < 20);
      hz.Br_Taken_Id = !hz.MulDiv_Id && ($urandom_range(0, 99) < 25);
      hz.Stall_Clr   = ($urandom_range(0, 99) < 3);
      model_eval();
      @(negedge clock);
      got = {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.MD_Start, hz.MD_Busy, hz.Stall_Cnt};
      exp = {e_pc, e_ifid, e_flush, e_bub, e_start, e_busy, e_cnt};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h required %h", i, got, exp);
      end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv_issue();
    test_hilo();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
